// File: rtl/dsp_capture_sequencer_if.sv
// Bus bundle for dsp_capture_sequencer: AHB-lite register port, raw sample stream in/out, chain-output monitor, sync and irq.
// Latency: n/a (wiring only).
// Backpressure: the raw source is never stalled; the chain applies backpressure through tready_m.
// slave  = sequencer side, master = system / testbench side.
interface dsp_capture_sequencer_if #(
    parameter int DW = 32
);
    logic [31:0]   haddr_s;
    logic [2:0]    hburst_s;
    logic [2:0]    hsize_s;
    logic [1:0]    htrans_s;
    logic [31:0]   hwdata_s;
    logic          hwrite_s;
    logic          hsel_s;
    logic [31:0]   hrdata_s;
    logic          hreadyout_s;
    logic          hresp_s;
    logic [DW-1:0] tdata_s;
    logic          tvalid_s;
    logic          tready_s;
    logic [DW-1:0] tdata_m;
    logic          tvalid_m;
    logic          tready_m;
    logic          tlast_mon;
    logic          tvalid_mon;
    logic          tready_mon;
    logic          sync_m;
    logic          irq;

    modport slave (
        input  haddr_s, hburst_s, hsize_s, htrans_s, hwdata_s, hwrite_s, hsel_s,
        output hrdata_s, hreadyout_s, hresp_s,
        input  tdata_s, tvalid_s,
        output tready_s,
        output tdata_m, tvalid_m,
        input  tready_m,
        input  tlast_mon, tvalid_mon, tready_mon,
        output sync_m, irq
    );

    modport master (
        output haddr_s, hburst_s, hsize_s, htrans_s, hwdata_s, hwrite_s, hsel_s,
        input  hrdata_s, hreadyout_s, hresp_s,
        output tdata_s, tvalid_s,
        input  tready_s,
        input  tdata_m, tvalid_m,
        output tready_m,
        output tlast_mon, tvalid_mon, tready_mon,
        input  sync_m, irq
    );
endinterface

// File: rtl/dsp_capture_sequencer.sv
// AHB-programmed capture sequencer: gates raw samples into the DSP chain, pulses frame sync, counts finished spectra.
// Latency: START data-phase edge N -> sync_m during cycle N+1 -> gate open from N+2; irq one cycle after its flag.
// Backpressure: source never stalled (tready_s=1); samples refused by the chain while running are dropped and counted.
// Ports: clk/reset_n/ce plain; bus (slave modport) carries AHB regs, stream in/out, chain monitor, sync_m, irq.
module dsp_capture_sequencer #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ce,
    dsp_capture_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, FLUSH = 2'd3} state_t;

    state_t             state_q, state_d;
    logic [2:0]         addr_q;
    logic               wr_q;
    logic               cont_q, done_ie_q, ovf_ie_q;
    logic [CNT_W-1:0]   frame_tgt_q, frames_done_q, drop_cnt_q;
    logic               done_q, ovf_q, irq_q;
    logic [10:0]        flush_cnt_q;
    logic               gate_open, sync_pulse;
    logic [31:0]        rdata;

    // Data-phase write decode against the address latched in the previous cycle.
    logic ctrl_wr, tgt_wr, status_wr;
    assign ctrl_wr   = wr_q && (addr_q == 3'd0);
    assign tgt_wr    = wr_q && (addr_q == 3'd1);
    assign status_wr = wr_q && (addr_q == 3'd2);

    // STOP wins over START when both are written together.
    logic start_req, stop_req, start_acc;
    assign start_req = ctrl_wr && bus.hwdata_s[0] && !bus.hwdata_s[1];
    assign stop_req  = ctrl_wr && bus.hwdata_s[1];
    assign start_acc = (state_q == IDLE) && start_req;

    logic             frame_beat, single_mode, tgt_hit, flush_timeout, drop, done_set;
    logic [CNT_W-1:0] fd_inc;
    assign frame_beat    = bus.tvalid_mon && bus.tready_mon && bus.tlast_mon;
    assign fd_inc        = (frames_done_q == '1) ? frames_done_q : frames_done_q + CNT_W'(1);
    // A zero target means "never stop on count", same as continuous mode.
    assign single_mode   = !cont_q && (frame_tgt_q != '0);
    assign tgt_hit       = frame_beat && single_mode && (fd_inc == frame_tgt_q);
    // 2048 consecutive FLUSH cycles without any output beat means nothing is in flight.
    assign flush_timeout = !bus.tvalid_mon && (flush_cnt_q == 11'h7FF);
    assign drop          = (state_q == RUN) && bus.tvalid_s && !bus.tready_m;
    assign done_set      = ((state_q == RUN) && tgt_hit) || ((state_q == FLUSH) && frame_beat);

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  state_q <= IDLE;
        else if (ce)   state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start_req) state_d = ARM;
            ARM:   state_d = RUN;
            RUN:   if (tgt_hit) state_d = IDLE;
                   else if (stop_req) state_d = FLUSH;
            FLUSH: if (frame_beat || flush_timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        gate_open  = (state_q == RUN);
        sync_pulse = (state_q == ARM);
    end

    // Registers, counters and AHB address latch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q        <= '0;
            wr_q          <= 1'b0;
            cont_q        <= 1'b0;
            done_ie_q     <= 1'b0;
            ovf_ie_q      <= 1'b0;
            frame_tgt_q   <= '0;
            frames_done_q <= '0;
            drop_cnt_q    <= '0;
            done_q        <= 1'b0;
            ovf_q         <= 1'b0;
            irq_q         <= 1'b0;
            flush_cnt_q   <= '0;
        end else if (ce) begin
            // Keep the last address when idle so read data stays stable.
            if (bus.hsel_s && bus.htrans_s[1]) begin
                addr_q <= bus.haddr_s[4:2];
                wr_q   <= bus.hwrite_s;
            end else begin
                wr_q   <= 1'b0;
            end

            if (ctrl_wr) begin
                cont_q    <= bus.hwdata_s[2];
                done_ie_q <= bus.hwdata_s[3];
                ovf_ie_q  <= bus.hwdata_s[4];
            end
            if (tgt_wr) frame_tgt_q <= bus.hwdata_s[CNT_W-1:0];

            if (start_acc)
                frames_done_q <= '0;
            else if (((state_q == RUN) || (state_q == FLUSH)) && frame_beat)
                frames_done_q <= fd_inc;

            if (start_acc)
                drop_cnt_q <= '0;
            else if (drop && (drop_cnt_q != '1))
                drop_cnt_q <= drop_cnt_q + CNT_W'(1);

            // Hardware set beats a simultaneous W1C.
            done_q <= !start_acc && (done_set || (done_q && !(status_wr && bus.hwdata_s[2])));
            ovf_q  <= drop || (ovf_q && !(status_wr && bus.hwdata_s[3]));

            flush_cnt_q <= ((state_q != FLUSH) || bus.tvalid_mon) ? 11'd0 : flush_cnt_q + 11'd1;
            irq_q       <= (done_q && done_ie_q) || (ovf_q && ovf_ie_q);
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr_q)
            3'd0: rdata = {27'd0, ovf_ie_q, done_ie_q, cont_q, 2'b00};
            3'd1: rdata = 32'(frame_tgt_q);
            3'd2: rdata = {28'd0, ovf_q, done_q, state_q};
            3'd3: rdata = 32'(frames_done_q);
            3'd4: rdata = 32'(drop_cnt_q);
            default: rdata = 32'd0;
        endcase
    end

    assign bus.hrdata_s    = rdata;
    assign bus.hreadyout_s = 1'b1;
    assign bus.hresp_s     = 1'b0;
    assign bus.tready_s    = 1'b1;
    assign bus.tdata_m     = DW'(bus.tdata_s);
    // Gate follows the current state even while ce is low.
    assign bus.tvalid_m    = bus.tvalid_s && gate_open;
    assign bus.sync_m      = sync_pulse;
    assign bus.irq         = irq_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.haddr_s[31:5], bus.haddr_s[1:0], bus.hburst_s,
                         bus.hsize_s, bus.htrans_s[0], bus.hwdata_s};
endmodule

// File: tb/tb_dsp_capture_sequencer.sv
// Directed bench for dsp_capture_sequencer: register table, single-shot, continuous+flush, overflow, reset and ce cases.
// Latency: n/a.
// Backpressure: drives tready_m low for a fixed burst to provoke drops.
module tb_dsp_capture_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ce = 1'b1;
    int   checks = 0;
    int   failures = 0;

    dsp_capture_sequencer_if #(.DW(32)) bus ();

    dsp_capture_sequencer #(.DW(32), .CNT_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        bus.hsel_s = 1'b1; bus.htrans_s = 2'b10; bus.hwrite_s = 1'b1; bus.haddr_s = a;
        tick();
        bus.hsel_s = 1'b0; bus.htrans_s = 2'b00; bus.hwrite_s = 1'b0; bus.hwdata_s = d;
        tick();
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        bus.hsel_s = 1'b1; bus.htrans_s = 2'b10; bus.hwrite_s = 1'b0; bus.haddr_s = a;
        tick();
        bus.hsel_s = 1'b0; bus.htrans_s = 2'b00;
        d = bus.hrdata_s;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        ahb_read(a, d);
        check(name, d, exp);
    endtask

    task automatic out_beat(input logic last);
        bus.tvalid_mon = 1'b1; bus.tready_mon = 1'b1; bus.tlast_mon = last;
        tick();
        bus.tvalid_mon = 1'b0; bus.tlast_mon = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'h00, 32'h0,          32'h0,    "rst_ctrl"};
        vecs[1]  = '{1'b0, 32'h04, 32'h0,          32'h0,    "rst_tgt"};
        vecs[2]  = '{1'b0, 32'h08, 32'h0,          32'h0,    "rst_status"};
        vecs[3]  = '{1'b0, 32'h0C, 32'h0,          32'h0,    "rst_frames"};
        vecs[4]  = '{1'b0, 32'h10, 32'h0,          32'h0,    "rst_drops"};
        vecs[5]  = '{1'b0, 32'h14, 32'h0,          32'h0,    "rst_unmapped"};
        vecs[6]  = '{1'b1, 32'h04, 32'h0000ABCD,   32'hABCD, "tgt_rw"};
        vecs[7]  = '{1'b1, 32'h04, 32'h00010005,   32'h0005, "tgt_trunc"};
        vecs[8]  = '{1'b1, 32'h00, 32'h0000001C,   32'h001C, "ctrl_rw"};
        vecs[9]  = '{1'b1, 32'h14, 32'hFFFFFFFF,   32'h0,    "unmapped_wr"};
        vecs[10] = '{1'b1, 32'h0C, 32'h00000055,   32'h0,    "frames_ro"};
        vecs[11] = '{1'b1, 32'h00, 32'h000000E4,   32'h0004, "ctrl_upper"};
        vecs[12] = '{1'b1, 32'h04, 32'h00000003,   32'h0003, "tgt_3"};

        bus.haddr_s = '0; bus.hburst_s = '0; bus.hsize_s = 3'd2; bus.htrans_s = '0;
        bus.hwdata_s = '0; bus.hwrite_s = 1'b0; bus.hsel_s = 1'b0;
        bus.tdata_s = 32'hCAFE0000; bus.tvalid_s = 1'b0; bus.tready_m = 1'b1;
        bus.tlast_mon = 1'b0; bus.tvalid_mon = 1'b0; bus.tready_mon = 1'b0;

        // Reset state
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check("rst_hreadyout", bus.hreadyout_s, 1);
        check("rst_hresp", bus.hresp_s, 0);
        check("rst_irq", bus.irq, 0);
        for (int i = 0; i < 4; i++) begin
            bus.tvalid_s = ~bus.tvalid_s;
            #1;
            check("idle_gate", bus.tvalid_m, 0);
            check("idle_sync", bus.sync_m, 0);
            tick();
        end

        // Register table
        for (int i = 0; i < 13; i++) begin
            logic [31:0] d;
            if (vecs[i].wr) ahb_write(vecs[i].addr, vecs[i].wdata);
            ahb_read(vecs[i].addr, d);
            check(vecs[i].name, d, vecs[i].exp);
        end

        // Single-shot of 3 frames with DONE interrupt
        bus.tvalid_s = 1'b1;
        check("pre_sync", bus.sync_m, 0);
        ahb_write(32'h00, 32'h09);
        check("arm_sync", bus.sync_m, 1);
        check("arm_gate", bus.tvalid_m, 0);
        tick();
        check("run_sync", bus.sync_m, 0);
        check("run_gate", bus.tvalid_m, 1);
        check("run_tdata", bus.tdata_m, 32'hCAFE0000);
        for (int i = 0; i < 3; i++) out_beat(1'b1);
        check("single_gate_closed", bus.tvalid_m, 0);
        check("single_irq_lag", bus.irq, 0);
        tick();
        check("single_irq", bus.irq, 1);
        read_check("single_status", 32'h08, 32'h04);
        read_check("single_frames", 32'h0C, 32'd3);
        read_check("single_drops", 32'h10, 32'd0);

        // Continuous, STOP mid-frame, flush on next tlast
        ahb_write(32'h00, 32'h05);
        tick();
        for (int i = 0; i < 5; i++) begin
            out_beat(1'b0);
            out_beat(1'b1);
        end
        out_beat(1'b0);
        ahb_write(32'h00, 32'h06);
        read_check("flush_status", 32'h08, 32'h03);
        read_check("flush_frames", 32'h0C, 32'd5);
        check("flush_gate", bus.tvalid_m, 0);
        out_beat(1'b1);
        read_check("flush_done_status", 32'h08, 32'h04);
        read_check("flush_frames6", 32'h0C, 32'd6);
        check("flush_irq_off", bus.irq, 0);

        // Overflow: 7 refused samples while running
        ahb_write(32'h00, 32'h01);
        tick();
        bus.tready_m = 1'b0;
        repeat (7) tick();
        bus.tready_m = 1'b1;
        read_check("ovf_drops", 32'h10, 32'd7);
        read_check("ovf_status", 32'h08, 32'h0A);
        check("ovf_irq_masked", bus.irq, 0);
        ahb_write(32'h00, 32'h10);
        tick();
        check("ovf_irq", bus.irq, 1);
        ahb_write(32'h08, 32'h08);
        tick();
        check("ovf_irq_clear", bus.irq, 0);
        read_check("ovf_w1c", 32'h08, 32'h02);
        ahb_write(32'h00, 32'h02);
        out_beat(1'b1);
        read_check("ovf_stop_status", 32'h08, 32'h04);
        read_check("ovf_stop_frames", 32'h0C, 32'd1);

        // Flush timeout with nothing in flight: exactly 2048 FLUSH cycles
        ahb_write(32'h00, 32'h01);
        tick();
        ahb_write(32'h00, 32'h02);
        read_check("to_flush", 32'h08, 32'h03);
        repeat (2045) @(posedge clk);
        #1;
        read_check("to_still_flush", 32'h08, 32'h03);
        tick();
        check("to_idle", bus.hrdata_s, 32'h00);

        // START+STOP together in IDLE is ignored
        ahb_write(32'h00, 32'h03);
        check("ss_sync", bus.sync_m, 0);
        tick();
        check("ss_sync2", bus.sync_m, 0);
        check("ss_gate", bus.tvalid_m, 0);
        read_check("ss_status", 32'h08, 32'h00);

        // Async reset mid-frame
        ahb_write(32'h00, 32'h01);
        tick();
        out_beat(1'b0);
        check("pre_rst_gate", bus.tvalid_m, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_gate", bus.tvalid_m, 0);
        check("rst_mid_rdata", bus.hrdata_s, 32'h0);
        check("rst_mid_sync", bus.sync_m, 0);
        tick();
        reset_n = 1'b1;
        tick();
        read_check("rst_mid_status", 32'h08, 32'h00);

        // FRAME_TGT=0 in single mode never stops; ce low freezes counting
        ahb_write(32'h04, 32'h00);
        ahb_write(32'h00, 32'h01);
        tick();
        for (int i = 0; i < 10; i++) out_beat(1'b1);
        ce = 1'b0;
        out_beat(1'b1);
        check("ce_gate", bus.tvalid_m, 1);
        ce = 1'b1;
        read_check("tgt0_frames", 32'h0C, 32'd10);
        read_check("tgt0_status", 32'h08, 32'h02);
        ahb_write(32'h00, 32'h02);
        out_beat(1'b1);
        read_check("tgt0_end", 32'h08, 32'h04);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
